// File: rtl/rdiv16_if.sv
// rtl/rdiv16_if.sv - request/result bundle for the 16/8 restoring divider
// Purpose: groups the divider's start/operand inputs and status/result outputs.
// Signals:
//   start - request to begin a division (master -> slave)
//   dvd   - 16-bit unsigned dividend   (master -> slave)
//   dvs   - 8-bit unsigned divisor     (master -> slave)
//   busy  - division in progress       (slave -> master)
//   done  - one-cycle result-valid pulse (slave -> master)
//   q     - 16-bit quotient            (slave -> master)
//   r     - 8-bit remainder            (slave -> master)
//   dbz   - divide-by-zero flag        (slave -> master)
interface rdiv16_if;
  logic        start;
  logic [15:0] dvd;
  logic [7:0]  dvs;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [7:0]  r;
  logic        dbz;

  modport master (
    output start, dvd, dvs,
    input  busy, done, q, r, dbz
  );

  modport slave (
    input  start, dvd, dvs,
    output busy, done, q, r, dbz
  );
endinterface

// File: rtl/rdiv16.sv
// rtl/rdiv16.sv - 16-bit by 8-bit unsigned restoring divider, one bit per cycle
// Purpose: sequential divider; 16 restoring steps per result, divide-by-zero
//          short-circuits to a saturated quotient.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - rdiv16_if.slave: start/dvd/dvs in, busy/done/q/r/dbz out
module rdiv16 (
  input  logic     clk,
  input  logic     rst_n,
  rdiv16_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Working registers (private to the iteration)
  logic [15:0] dvd_w;
  logic [7:0]  dvs_w;
  logic [7:0]  pr;
  logic [15:0] qw;
  logic [3:0]  cnt;

  // Result registers (only touched when a result is produced)
  logic [15:0] q_out;
  logic [7:0]  r_out;
  logic        dbz_out;

  logic        accept;
  logic        busy_c;
  logic        done_c;
  logic        dz;
  logic [8:0]  pr9;
  logic        ge;
  logic [7:0]  diff;
  logic [7:0]  pr_nxt;

  // One restoring step. The compare is 9 bits so divisors above 127 work;
  // when pr9 >= dvs the true difference is below 256, so an 8-bit subtract
  // of the low bits yields exactly that difference.
  always_comb begin
    pr9    = {pr, dvd_w[15]};
    ge     = (pr9 >= {1'b0, dvs_w});
    diff   = pr9[7:0] - dvs_w;
    pr_nxt = ge ? diff : pr9[7:0];
    dz     = (dvs_w == 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A start seen on the DONE exit edge is taken so that a held start
  // restarts every 17 cycles; in RUN it is ignored.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (dz || (cnt == 4'd15)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_w   <= 16'h0000;
      dvs_w   <= 8'h00;
      pr      <= 8'h00;
      qw      <= 16'h0000;
      cnt     <= 4'd0;
      q_out   <= 16'h0000;
      r_out   <= 8'h00;
      dbz_out <= 1'b0;
    end else if (accept) begin
      dvd_w <= bus.dvd;
      dvs_w <= bus.dvs;
      pr    <= 8'h00;
      qw    <= 16'h0000;
      cnt   <= 4'd0;
    end else if (state == RUN) begin
      if (dz) begin
        // Zero divisor: dvd_w has not been shifted yet, so its low byte is
        // still the original dividend's low byte.
        q_out   <= 16'hFFFF;
        r_out   <= dvd_w[7:0];
        dbz_out <= 1'b1;
      end else begin
        dvd_w <= {dvd_w[14:0], 1'b0};
        pr    <= pr_nxt;
        qw    <= {qw[14:0], ge};
        cnt   <= cnt + 4'd1;
        if (cnt == 4'd15) begin
          q_out   <= {qw[14:0], ge};
          r_out   <= pr_nxt;
          dbz_out <= 1'b0;
        end
      end
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.q    = q_out;
  assign bus.r    = r_out;
  assign bus.dbz  = dbz_out;

endmodule

// File: tb/tb_rdiv16.sv
// tb/tb_rdiv16.sv - directed and streaming checks for rdiv16
// Purpose: drives rdiv16 through its interface and compares against
//          hand-computed results and a divide reference.
module tb_rdiv16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rdiv16_if bus ();

  rdiv16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge. mode 0: plain; mode 1: operand change and
  // stray start during RUN; mode 2: reset pulse mid-RUN.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic ed,
                         input int el, input int mode);
    int          lat;
    int          dones;
    logic [15:0] got_q;
    logic [7:0]  got_r;
    logic        got_dbz;
    logic        got_busy;
    lat      = -1;
    dones    = 0;
    got_q    = 16'h0;
    got_r    = 8'h0;
    got_dbz  = 1'b0;
    got_busy = 1'b0;
    bus.start = 1'b1;
    bus.dvd   = a;
    bus.dvs   = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) chk({tag, "_busy_k"}, bus.busy, 1);
      if (mode == 1 && j == 2) bus.dvd = 16'hBEEF;
      if (mode == 1 && j == 4) begin
        bus.start = 1'b1;
        bus.dvd   = 16'h0003;
        bus.dvs   = 8'd1;
      end
      if (mode == 1 && j == 5) bus.start = 1'b0;
      if (mode == 2 && j == 8) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_busy"}, bus.busy, 0);
        chk({tag, "_rst_done"}, bus.done, 0);
        chk({tag, "_rst_q"}, bus.q, 0);
        chk({tag, "_rst_r"}, bus.r, 0);
        chk({tag, "_rst_dbz"}, bus.dbz, 0);
      end
      if (bus.done) begin
        dones++;
        if (lat < 0) begin
          lat      = j;
          got_q    = bus.q;
          got_r    = bus.r;
          got_dbz  = bus.dbz;
          got_busy = bus.busy;
        end
      end
    end
    if (mode == 2) begin
      chk({tag, "_no_done"}, dones, 0);
    end else begin
      chk({tag, "_ndone"}, dones, 1);
      chk({tag, "_lat"}, lat, el);
      chk({tag, "_q"}, got_q, eq);
      chk({tag, "_r"}, got_r, er);
      chk({tag, "_dbz"}, got_dbz, ed);
      chk({tag, "_busy_at_done"}, got_busy, 0);
    end
  endtask

  task automatic run_stream(input int count);
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ed;
    int          el;
    int          j;
    logic        got;
    a = 16'($urandom);
    b = 8'($urandom_range(0, 255));
    bus.start = 1'b1;
    bus.dvd   = a;
    bus.dvs   = b;
    @(posedge clk);
    for (int n = 0; n < count; n++) begin
      got = 1'b0;
      j   = 0;
      while (!got && j < 40) begin
        @(negedge clk);
        if (bus.done) got = 1'b1;
        else j++;
      end
      if (!got) begin
        chk("stream_timeout", 0, 1);
        bus.start = 1'b0;
        return;
      end
      if (b == 8'h00) begin
        eq = 16'hFFFF;
        er = a[7:0];
        ed = 1'b1;
        el = 1;
      end else begin
        eq = a / {8'h00, b};
        er = 8'(a % {8'h00, b});
        ed = 1'b0;
        el = 16;
      end
      chk("stream_lat", j, el);
      chk("stream_q", bus.q, eq);
      chk("stream_r", bus.r, er);
      chk("stream_dbz", bus.dbz, ed);
      if (n == count - 1) begin
        bus.start = 1'b0;
      end else begin
        a = 16'($urandom);
        b = 8'($urandom_range(0, 255));
        bus.dvd = a;
        bus.dvs = b;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dvd   = 16'h0000;
    bus.dvs   = 8'h00;
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_q", bus.q, 0);
    chk("reset_r", bus.r, 0);
    chk("reset_dbz", bus.dbz, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Start on the first edge after reset release
    run_div("d100_7", 16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 16, 0);
    run_div("d65535_1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 16, 0);
    run_div("d65535_255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16, 0);
    run_div("d5_9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 16, 0);
    run_div("dbz", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 1, 0);
    run_div("d40000_200", 16'd40000, 8'd200, 16'd200, 8'd0, 1'b0, 16, 0);
    run_div("d1000_7_ign", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, 1);
    run_div("rst_mid", 16'd1000, 8'd3, 16'd0, 8'd0, 1'b0, 16, 2);
    rst_n = 1'b1;
    run_div("d200_13", 16'd200, 8'd13, 16'd15, 8'd5, 1'b0, 16, 0);
    run_stream(1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
